// File: rtl/fc_rx_credit_ctrl.sv
// Receive-side flow-control credit controller for one posted-style credit class.
// Tracks allocated (CA) and received (CR) credits, sends InitFC on link-up, then
// sends UpdateFC when pending credits cross a threshold or the keep-alive timer expires.
module fc_rx_credit_ctrl #(
  parameter int HDR_CREDITS  = 32,
  parameter int DATA_CREDITS = 512,
  parameter int INIT_REPEAT  = 4,
  parameter int HDR_THRESH   = 8,
  parameter int DATA_THRESH  = 64,
  parameter int UPDATE_TIMER = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_up_i,
  input  logic        rx_tlp_valid_i,
  input  logic [7:0]  rx_tlp_size_i,
  input  logic        rel_valid_i,
  input  logic [7:0]  rel_hdr_i,
  input  logic [11:0] rel_data_i,
  input  logic        dllp_ready_i,
  output logic        initfc_valid_o,
  output logic [7:0]  initfc_hdr_credit_o,
  output logic [11:0] initfc_data_credit_o,
  output logic        updatefc_valid_o,
  output logic [7:0]  updatefc_hdr_credit_o,
  output logic [11:0] updatefc_data_credit_o,
  output logic        fc_active_o,
  output logic        overflow_err_o
);

  localparam logic [7:0]  HDR_INIT  = 8'(HDR_CREDITS);
  localparam logic [11:0] DATA_INIT = 12'(DATA_CREDITS);
  localparam logic [7:0]  HDR_TH    = 8'(HDR_THRESH);
  localparam logic [11:0] DATA_TH   = 12'(DATA_THRESH);
  localparam int          TW        = $clog2(UPDATE_TIMER + 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(UPDATE_TIMER - 1);
  localparam int          IW        = $clog2(INIT_REPEAT + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_REPEAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_ACTIVE, S_UPD_WAIT} state_t;

  state_t        state, state_d;
  logic [IW-1:0] init_cnt;
  logic [TW-1:0] timer;
  logic [7:0]    ca_hdr, cr_hdr, adv_hdr, upd_hdr;
  logic [11:0]   ca_data, cr_data, adv_data, upd_data;
  logic [7:0]    pend_hdr, ca_hdr_nx, cr_hdr_nx, diff_hdr;
  logic [11:0]   pend_data, ca_data_nx, cr_data_nx, diff_data;
  logic [6:0]    rx_dcred;
  logic          init_hs, upd_hs, trigger, ovf_nx, reinit;
  logic          init_vld_d, upd_vld_d, active_d;

  assign initfc_hdr_credit_o    = HDR_INIT;
  assign initfc_data_credit_o   = DATA_INIT;
  assign updatefc_hdr_credit_o  = upd_hdr;
  assign updatefc_data_credit_o = upd_data;

  assign init_hs   = initfc_valid_o & dllp_ready_i;
  assign upd_hs    = updatefc_valid_o & dllp_ready_i;
  assign pend_hdr  = ca_hdr - adv_hdr;
  assign pend_data = ca_data - adv_data;
  assign trigger   = (pend_hdr >= HDR_TH) || (pend_data >= DATA_TH) || (timer == TMR_LAST);
  // Counters sit at their initial values whenever the link is down or the FSM is idle.
  assign reinit    = !link_up_i || (state == S_IDLE);

  // ceil(size/4): whole DW groups plus one for any partial group.
  assign rx_dcred   = {1'b0, rx_tlp_size_i[7:2]} + {6'd0, |rx_tlp_size_i[1:0]};
  assign cr_hdr_nx  = cr_hdr + {7'd0, rx_tlp_valid_i};
  assign cr_data_nx = cr_data + (rx_tlp_valid_i ? {5'd0, rx_dcred} : 12'd0);
  assign ca_hdr_nx  = ca_hdr + (rel_valid_i ? rel_hdr_i : 8'd0);
  assign ca_data_nx = ca_data + (rel_valid_i ? rel_data_i : 12'd0);

  // Overflow when received has run ahead of allocated by 1..half-range (modular compare).
  assign diff_hdr  = cr_hdr_nx - ca_hdr_nx;
  assign diff_data = cr_data_nx - ca_data_nx;
  assign ovf_nx    = (!diff_hdr[7] && (diff_hdr != 8'd0)) ||
                     (!diff_data[11] && (diff_data != 12'd0));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // FSM next-state logic; link drop overrides everything
  always_comb begin
    state_d = state;
    if (!link_up_i) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     state_d = S_INIT;
        S_INIT:     if (init_hs && (init_cnt == INIT_LAST)) state_d = S_ACTIVE;
        S_ACTIVE:   if (trigger) state_d = S_UPD_WAIT;
        S_UPD_WAIT: if (upd_hs) state_d = S_ACTIVE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // FSM output decode of the next state, registered below so outputs are flop-driven
  always_comb begin
    init_vld_d = (state_d == S_INIT);
    upd_vld_d  = (state_d == S_UPD_WAIT);
    active_d   = (state_d == S_ACTIVE) || (state_d == S_UPD_WAIT);
  end

  // Registered FSM outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      initfc_valid_o   <= 1'b0;
      updatefc_valid_o <= 1'b0;
      fc_active_o      <= 1'b0;
    end else begin
      initfc_valid_o   <= init_vld_d;
      updatefc_valid_o <= upd_vld_d;
      fc_active_o      <= active_d;
    end
  end

  // Credit counters, handshake counter, keep-alive timer, UpdateFC latch and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ca_hdr <= HDR_INIT;  ca_data <= DATA_INIT;
      cr_hdr <= 8'd0;      cr_data <= 12'd0;
      adv_hdr <= HDR_INIT; adv_data <= DATA_INIT;
      upd_hdr <= HDR_INIT; upd_data <= DATA_INIT;
      init_cnt <= '0;
      timer <= '0;
      overflow_err_o <= 1'b0;
    end else if (reinit) begin
      ca_hdr <= HDR_INIT;  ca_data <= DATA_INIT;
      cr_hdr <= 8'd0;      cr_data <= 12'd0;
      adv_hdr <= HDR_INIT; adv_data <= DATA_INIT;
      upd_hdr <= HDR_INIT; upd_data <= DATA_INIT;
      init_cnt <= '0;
      timer <= '0;
    end else begin
      ca_hdr  <= ca_hdr_nx;
      ca_data <= ca_data_nx;
      cr_hdr  <= cr_hdr_nx;
      cr_data <= cr_data_nx;
      if (ovf_nx) overflow_err_o <= 1'b1;
      if ((state == S_INIT) && init_hs) init_cnt <= init_cnt + 1'b1;
      if (state == S_ACTIVE) begin
        // Latch pre-release CA; same-cycle releases stay pending for the next update.
        if (trigger) begin
          upd_hdr  <= ca_hdr;
          upd_data <= ca_data;
        end else begin
          timer <= timer + 1'b1;
        end
      end
      if ((state == S_UPD_WAIT) && upd_hs) begin
        adv_hdr  <= upd_hdr;
        adv_data <= upd_data;
        timer    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fc_rx_credit_ctrl.sv
// Bench for fc_rx_credit_ctrl: directed test-plan scenarios plus randomized traffic,
// every cycle compared against a transaction-level credit model.
module tb_fc_rx_credit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_up = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_size = 8'd0;
  logic        rel_valid = 1'b0;
  logic [7:0]  rel_hdr = 8'd0;
  logic [11:0] rel_data = 12'd0;
  logic        ready = 1'b0;
  logic        initfc_valid_o, updatefc_valid_o, fc_active_o, overflow_err_o;
  logic [7:0]  initfc_hdr_credit_o, updatefc_hdr_credit_o;
  logic [11:0] initfc_data_credit_o, updatefc_data_credit_o;

  always #5 clk = ~clk;

  fc_rx_credit_ctrl dut (
    .clk(clk), .rst_n(rst_n), .link_up_i(link_up),
    .rx_tlp_valid_i(rx_valid), .rx_tlp_size_i(rx_size),
    .rel_valid_i(rel_valid), .rel_hdr_i(rel_hdr), .rel_data_i(rel_data),
    .dllp_ready_i(ready),
    .initfc_valid_o(initfc_valid_o), .initfc_hdr_credit_o(initfc_hdr_credit_o),
    .initfc_data_credit_o(initfc_data_credit_o),
    .updatefc_valid_o(updatefc_valid_o), .updatefc_hdr_credit_o(updatefc_hdr_credit_o),
    .updatefc_data_credit_o(updatefc_data_credit_o),
    .fc_active_o(fc_active_o), .overflow_err_o(overflow_err_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 init, 2 active, 3 waiting for UpdateFC accept.
  int m_ph, m_hs, m_tmr;
  int m_ca_h, m_ca_d, m_cr_h, m_cr_d, m_adv_h, m_adv_d, m_lat_h, m_lat_d;
  bit m_ovf;

  function automatic void model_init_counters();
    m_ca_h = 32; m_ca_d = 512; m_cr_h = 0; m_cr_d = 0;
    m_adv_h = 32; m_adv_d = 512; m_lat_h = 32; m_lat_d = 512;
    m_tmr = 0; m_hs = 0;
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_ovf = 0;
    model_init_counters();
  endfunction

  function automatic void model_step();
    bit hs_i, hs_u, trig;
    int pend_h, pend_d, dh, dd;
    hs_i = (m_ph == 1) && ready;
    hs_u = (m_ph == 3) && ready;
    if (!link_up || m_ph == 0) begin
      model_init_counters();
      m_ph = link_up ? 1 : 0;
    end else begin
      pend_h = (m_ca_h - m_adv_h) & 255;
      pend_d = (m_ca_d - m_adv_d) & 4095;
      trig = (pend_h >= 8) || (pend_d >= 64) || (m_tmr == 255);
      case (m_ph)
        1: if (hs_i) begin m_hs++; if (m_hs == 4) m_ph = 2; end
        2: if (trig) begin m_lat_h = m_ca_h; m_lat_d = m_ca_d; m_ph = 3; end
           else m_tmr++;
        3: if (hs_u) begin m_adv_h = m_lat_h; m_adv_d = m_lat_d; m_tmr = 0; m_ph = 2; end
        default: m_ph = 0;
      endcase
      if (rx_valid) begin
        m_cr_h = (m_cr_h + 1) & 255;
        m_cr_d = (m_cr_d + (int'(rx_size) + 3) / 4) & 4095;
      end
      if (rel_valid) begin
        m_ca_h = (m_ca_h + int'(rel_hdr)) & 255;
        m_ca_d = (m_ca_d + int'(rel_data)) & 4095;
      end
      dh = (m_cr_h - m_ca_h) & 255;
      dd = (m_cr_d - m_ca_d) & 4095;
      if ((dh >= 1 && dh <= 127) || (dd >= 1 && dd <= 2047)) m_ovf = 1;
    end
  endfunction

  task automatic compare_all();
    chk("initfc_valid", initfc_valid_o, m_ph == 1);
    chk("updatefc_valid", updatefc_valid_o, m_ph == 3);
    chk("fc_active", fc_active_o, m_ph >= 2);
    chk("overflow", overflow_err_o, m_ovf);
    chk("upd_hdr", updatefc_hdr_credit_o, m_lat_h);
    chk("upd_data", updatefc_data_credit_o, m_lat_d);
    chk("init_hdr", initfc_hdr_credit_o, 32);
    chk("init_data", initfc_data_credit_o, 512);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic quiet();
    rx_valid = 0; rx_size = 0; rel_valid = 0; rel_hdr = 0; rel_data = 0;
  endtask

  task automatic restart();
    quiet();
    link_up = 0; ready = 1; tick();
    link_up = 1; repeat (6) tick();
  endtask

  // Waits (bounded) for an UpdateFC, checks its values, then spends the handshake cycle.
  task automatic wait_upd(string tag, int eh, int ed, int budget);
    int i = 0;
    while (!updatefc_valid_o && i < budget) begin tick(); i++; end
    chk({tag, "_seen"}, updatefc_valid_o, 1);
    chk({tag, "_hdr"}, updatefc_hdr_credit_o, eh);
    chk({tag, "_data"}, updatefc_data_credit_o, ed);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, hs;
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst_n = 1;

    // InitFC with ready always high: four valid cycles then active
    link_up = 1; ready = 1; cnt = 0;
    repeat (8) begin tick(); if (initfc_valid_o) cnt++; end
    chk("init_cycles", cnt, 4);
    chk("init_active", fc_active_o, 1);

    // InitFC with ready low for three cycles mid-sequence
    link_up = 0; tick(); link_up = 1; hs = 0;
    for (int i = 0; i < 14; i++) begin
      ready = !(i >= 2 && i < 5);
      if (initfc_valid_o && ready) hs++;
      tick();
    end
    chk("init_hs_gap", hs, 4);
    chk("init_gap_active", fc_active_o, 1);

    // Header threshold
    restart();
    rel_valid = 1; rel_hdr = 1; rel_data = 0;
    repeat (8) tick();
    quiet();
    wait_upd("hdr_th", 40, 512, 10);
    repeat (5) tick();
    chk("hdr_th_quiet", updatefc_valid_o, 0);

    // Data threshold and rounding
    restart();
    rx_valid = 1; rx_size = 9;
    repeat (5) tick();
    quiet();
    rel_valid = 1; rel_data = 64;
    tick();
    quiet();
    wait_upd("data_th", 32, 576, 10);

    // Keep-alive
    restart();
    wait_upd("keepalive", 32, 512, 300);

    // Header wrap
    restart();
    rel_valid = 1; rel_hdr = 255; tick(); quiet();
    wait_upd("wrap1", 31, 512, 10);
    rel_valid = 1; rel_hdr = 255; tick(); quiet();
    wait_upd("wrap2", 30, 512, 10);

    // Overflow: 33rd header without release
    restart();
    rx_valid = 1; rx_size = 0;
    repeat (32) tick();
    quiet();
    chk("ovf_32", overflow_err_o, 0);
    rx_valid = 1; tick(); quiet();
    chk("ovf_rise", overflow_err_o, 1);
    restart();
    chk("ovf_sticky", overflow_err_o, 1);
    rst_n = 0;
    model_reset();
    #1;
    chk("ovf_reset", overflow_err_o, 0);
    compare_all();
    @(negedge clk);
    rst_n = 1;

    // Link drop while UpdateFC is stalled
    restart();
    ready = 0;
    rel_valid = 1; rel_hdr = 8; tick(); quiet();
    wait_upd("stall", 40, 512, 10);
    repeat (3) tick();
    chk("stall_hold", updatefc_valid_o, 1);
    link_up = 0; tick();
    chk("drop_uvld", updatefc_valid_o, 0);
    chk("drop_active", fc_active_o, 0);
    chk("drop_upd_hdr", updatefc_hdr_credit_o, 32);
    link_up = 1; ready = 1; tick();
    chk("relink_init", initfc_valid_o, 1);
    chk("relink_hdr", initfc_hdr_credit_o, 32);
    chk("relink_data", initfc_data_credit_o, 512);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      link_up   = ($urandom_range(0, 299) != 0);
      ready     = ($urandom_range(0, 3) != 0);
      rx_valid  = ($urandom_range(0, 2) == 0);
      rx_size   = 8'($urandom_range(0, 255));
      rel_valid = ($urandom_range(0, 1) == 0);
      rel_hdr   = 8'($urandom_range(0, 3));
      rel_data  = 12'($urandom_range(0, 40));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_rx_credit_ctrl.md
# fc_rx_credit_ctrl

Receive-side flow-control credit controller. It tracks receive-buffer credits (allocated vs. received) for one posted-style credit class. It issues InitFC on link-up and UpdateFC DLLP requests as the consumer frees buffer space. Its InitFC/UpdateFC outputs are what the link partner's transmit flow-control controller consumes as `initfc_*` / `updatefc_*` inputs. It sits between the RX TLP buffer and the DLLP transmit scheduler.

## Interface
Parameters:
- `HDR_CREDITS`, 32: header credits advertised at InitFC (1..127)
- `DATA_CREDITS`, 512: data credits advertised at InitFC (1..2047); 1 data credit = 4 DW
- `INIT_REPEAT`, 4: number of InitFC handshakes before entering ACTIVE
- `HDR_THRESH`, 8: pending header credits that force an UpdateFC
- `DATA_THRESH`, 64: pending data credits that force an UpdateFC
- `UPDATE_TIMER`, 256: ACTIVE cycles without an UpdateFC handshake before a keep-alive UpdateFC

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `link_up_i`  in  1  data link up; deassertion aborts to IDLE
- `rx_tlp_valid_i`  in  1  one TLP accepted into the RX buffer this cycle
- `rx_tlp_size_i`  in  8  payload size in DW (0 = no payload)
- `rel_valid_i`  in  1  consumer freed buffer space this cycle
- `rel_hdr_i`  in  8  header credits freed
- `rel_data_i`  in  12  data credits freed
- `dllp_ready_i`  in  1  DLLP scheduler accepts the presented FC DLLP
- `initfc_valid_o`  out  1  InitFC request
- `initfc_hdr_credit_o`  out  8  InitFC header credits
- `initfc_data_credit_o`  out  12  InitFC data credits
- `updatefc_valid_o`  out  1  UpdateFC request
- `updatefc_hdr_credit_o`  out  8  advertised cumulative header limit (CA_hdr)
- `updatefc_data_credit_o`  out  12  advertised cumulative data limit (CA_data)
- `fc_active_o`  out  1  FSM in ACTIVE or UPD_WAIT
- `overflow_err_o`  out  1  sticky receiver-overflow error

## Operation
- **Counters:**
  - CA_hdr (8b) and CA_data (12b) hold credits allocated.
  - CR_hdr (8b) and CR_data (12b) hold credits received.
  - ADV_hdr and ADV_data hold the last advertised values.
  - All counters are modular: wrap mod 2^8 / 2^12.
  - Initial values: CA = HDR_CREDITS/DATA_CREDITS, CR = 0, ADV = CA.
- **Receive:** when `rx_tlp_valid_i` is high, CR_hdr += 1 and CR_data += ceil(rx_tlp_size_i/4). A size of 0 adds 0 data credits.
- **Overflow:** raise a sticky `overflow_err_o` when, after the update, (CR − CA) mod 2^N lies in [1, 2^(N−1)−1] for either counter. It clears only on reset.
- **Release:** when `rel_valid_i` is high, CA_hdr += rel_hdr_i and CA_data += rel_data_i. Receive and release in the same cycle are both applied.
- **Pending credits:** pend_hdr = CA_hdr − ADV_hdr and pend_data = CA_data − ADV_data, both modular.
- **FSM:**
  - **IDLE:** all counters are at their initial values. When `link_up_i` = 1, go to INIT.
  - **INIT:**
    - Drive `initfc_valid_o` = 1 with HDR_CREDITS/DATA_CREDITS.
    - Count handshakes (`initfc_valid_o` && `dllp_ready_i`).
    - After INIT_REPEAT handshakes, go to ACTIVE on the cycle following the last handshake.
  - **ACTIVE:** the update trigger is (pend_hdr ≥ HDR_THRESH) OR (pend_data ≥ DATA_THRESH) OR (timer == UPDATE_TIMER−1). On trigger, latch CA into the UpdateFC outputs and go to UPD_WAIT.
  - **UPD_WAIT:**
    - `updatefc_valid_o` = 1 and the outputs are held stable.
    - On `dllp_ready_i`: ADV ← latched values, the timer is cleared, and the FSM returns to ACTIVE.
    - Releases arriving in UPD_WAIT accumulate into CA only. They are not added to the latched outputs.
  - **Any state:** `link_up_i` = 0 goes to IDLE next cycle. It reinitialises all counters, clears the timer, and drops both valids. `overflow_err_o` is retained.
- **Timer:** increments each ACTIVE cycle and is held in UPD_WAIT. When it expires, a keep-alive UpdateFC is sent even if pend = 0.
- At most one valid output is high at any time.

## Timing
- **Reset values:**
  - All valids = 0, `fc_active_o` = 0, `overflow_err_o` = 0.
  - initfc_* credit outputs = HDR_CREDITS/DATA_CREDITS.
  - updatefc_* credit outputs = HDR_CREDITS/DATA_CREDITS.
  - FSM = IDLE.
- All outputs are registered.
- `initfc_valid_o` rises 1 cycle after `link_up_i` is sampled high in IDLE.
- **Counter latency:** receive/release inputs update the counters at the sampling edge and are visible to overflow/trigger logic the next cycle. `overflow_err_o` asserts 1 cycle after the offending TLP is sampled.
- **Update latency:** `updatefc_valid_o` asserts 1 cycle after the trigger evaluates true in ACTIVE. Minimum spacing between UpdateFC handshakes is 2 cycles.
- **Handshake:** a valid stays high with stable data until sampled with `dllp_ready_i` = 1. It deasserts the cycle after the handshake.
- `fc_active_o` = 1 from the first ACTIVE cycle.

## Test plan
- **InitFC sequence:**
  - Stimulus: reset, `link_up_i` = 1, `dllp_ready_i` = 1 always.
  - Required response: `initfc_valid_o` high 4 consecutive cycles with 32/512, then `fc_active_o` = 1. With ready low for 3 cycles mid-sequence, valid holds and exactly 4 handshakes occur.
- **Header threshold:**
  - Stimulus: in ACTIVE, release 1 hdr / 0 data per cycle for 8 cycles.
  - Required response: one UpdateFC with hdr = 40, data = 512. ADV_hdr = 40 after handshake.
- **Data threshold and rounding:**
  - Stimulus: receive 5 TLPs of size 9 DW, making CR_data = 15. Then release 64 data credits in one cycle.
  - Required response: UpdateFC data = 576 (0x240), hdr = 32.
- **Keep-alive and wrap:**
  - Stimulus: idle in ACTIVE for 256 cycles. Separately, release 255 hdr credits twice to wrap CA_hdr.
  - Required response: the idle case yields an UpdateFC with unchanged values 32/512. The wrap case advertises (32+510) mod 256 = 30.
- **Overflow:**
  - Stimulus: receive 33 TLPs with no release.
  - Required response: `overflow_err_o` rises 1 cycle after the 33rd TLP and stays high through link down/up; reset clears it.
- **Link drop mid-update:**
  - Stimulus: hold `dllp_ready_i` = 0 in UPD_WAIT, then deassert `link_up_i`.
  - Required response: valid drops next cycle, FSM returns to IDLE, counters reinitialise. The next link-up restarts InitFC with 32/512.
